// File: rtl/clock_pkg.sv
// Shared types, limits and BCD helpers for the time-of-day counter.
// TWELVE_HOUR_EN selects 01..12 hour counting; otherwise hours run 00..23.
package clock_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t tens;
    bcd_t ones;
  } bcd2_t;

  localparam int unsigned DEFAULT_DIV = 10_000_000;
  localparam int unsigned SEC_MAX     = 59;
  localparam int unsigned MIN_MAX     = 59;
  localparam int unsigned HR24_MAX    = 23;
  localparam int unsigned HR12_MAX    = 12;

  localparam bcd2_t ZERO2    = '{tens: 4'd0, ones: 4'd0};
  localparam bcd2_t HR24_RST = '{tens: 4'd0, ones: 4'd0};
  localparam bcd2_t HR12_RST = '{tens: 4'd1, ones: 4'd2};

`ifdef TWELVE_HOUR_EN
  localparam bcd2_t HR_RST = HR12_RST;
`else
  localparam bcd2_t HR_RST = HR24_RST;
`endif

  function automatic int unsigned bcd2_val(bcd2_t v);
    return ({28'd0, v.tens} * 32'd10) + {28'd0, v.ones};
  endfunction

  // Two-digit BCD increment wrapping 59 -> 00 (seconds and minutes).
  function automatic bcd2_t bcd2_inc(bcd2_t v);
    bcd2_t r;
    r = v;
    if (v.ones == 4'd9) begin
      r.ones = 4'd0;
      r.tens = (v.tens == 4'd5) ? 4'd0 : v.tens + 4'd1;
    end else begin
      r.ones = v.ones + 4'd1;
    end
    return r;
  endfunction

  function automatic bcd2_t hr_inc(bcd2_t v);
    bcd2_t r;
    r = v;
`ifdef TWELVE_HOUR_EN
    if (v.tens == 4'd1 && v.ones == 4'd2) begin
      r = '{tens: 4'd0, ones: 4'd1};
    end else if (v.ones == 4'd9) begin
      r = '{tens: v.tens + 4'd1, ones: 4'd0};
    end else begin
      r.ones = v.ones + 4'd1;
    end
`else
    if (v.tens == 4'd2 && v.ones == 4'd3) begin
      r = ZERO2;
    end else if (v.ones == 4'd9) begin
      r = '{tens: v.tens + 4'd1, ones: 4'd0};
    end else begin
      r.ones = v.ones + 4'd1;
    end
`endif
    return r;
  endfunction

  function automatic logic bcd2_legal(bcd2_t v, int unsigned max);
    return (v.ones <= 4'd9) && (v.tens <= 4'd9) && (bcd2_val(v) <= max);
  endfunction

  function automatic logic hr_legal(bcd2_t v);
`ifdef TWELVE_HOUR_EN
    return bcd2_legal(v, HR12_MAX) && (bcd2_val(v) != 0);
`else
    return bcd2_legal(v, HR24_MAX);
`endif
  endfunction

endpackage

// File: rtl/tick_prescaler.sv
// Free-running 0..DIV-1 divider; tick is high in the cycle the count equals DIV-1.
module tick_prescaler #(
  parameter int unsigned DIV   = 10_000_000,
  parameter int unsigned DIV_W = 24
) (
  input  logic ADC_CLK_10,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam logic [DIV_W-1:0] Last = DIV_W'(DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = enable && (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (enable) begin
      cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
    end
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bcd_time_counter.sv
// BCD time-of-day counter with 1 Hz prescaler and minute/hour set buttons.
// TWELVE_HOUR_EN (via clock_pkg) switches hours to 01..12 with a 12:00 reset value.
module bcd_time_counter
  import clock_pkg::*;
#(
  parameter int unsigned DIV   = DEFAULT_DIV,
  parameter int unsigned DIV_W = 24
) (
  input  logic       ADC_CLK_10,
  input  logic       reset,
  input  logic       run,
  input  logic       inc_min_btn,
  input  logic       inc_hr_btn,
  output logic [3:0] h10,
  output logic [3:0] h1,
  output logic [3:0] m10,
  output logic [3:0] m1,
  output logic       sec_tick,
  output logic       colon
);

  logic [1:0] min_sync_q, hr_sync_q;
  logic       min_prev_q, hr_prev_q;
  logic       min_pulse_q, hr_pulse_q;

  bcd2_t sec_q, sec_d;
  bcd2_t min_q, min_d;
  bcd2_t hr_q, hr_d;
  logic  sec_tick_q, sec_tick_d;
  logic  tick;
  logic  state_legal;

  // A minute-set pulse also restarts the second from zero.
  tick_prescaler #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) u_prescaler (
    .ADC_CLK_10 (ADC_CLK_10),
    .reset      (reset | min_pulse_q),
    .enable     (run),
    .tick       (tick)
  );

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      min_sync_q  <= '0;
      hr_sync_q   <= '0;
      min_prev_q  <= 1'b0;
      hr_prev_q   <= 1'b0;
      min_pulse_q <= 1'b0;
      hr_pulse_q  <= 1'b0;
    end else begin
      min_sync_q  <= {min_sync_q[0], inc_min_btn};
      hr_sync_q   <= {hr_sync_q[0], inc_hr_btn};
      min_prev_q  <= min_sync_q[1];
      hr_prev_q   <= hr_sync_q[1];
      min_pulse_q <= min_sync_q[1] & ~min_prev_q;
      hr_pulse_q  <= hr_sync_q[1] & ~hr_prev_q;
    end
  end

  assign state_legal = bcd2_legal(sec_q, SEC_MAX) && bcd2_legal(min_q, MIN_MAX) && hr_legal(hr_q);

  always_comb begin
    sec_d      = sec_q;
    min_d      = min_q;
    hr_d       = hr_q;
    sec_tick_d = 1'b0;
    if (min_pulse_q) begin
      sec_d = ZERO2;
      min_d = bcd2_inc(min_q);
    end else if (tick) begin
      sec_tick_d = 1'b1;
      sec_d      = bcd2_inc(sec_q);
      if (bcd2_val(sec_q) == SEC_MAX) begin
        min_d = bcd2_inc(min_q);
        if (bcd2_val(min_q) == MIN_MAX) begin
          hr_d = hr_inc(hr_q);
        end
      end
    end
    // Applied on top of any carry, so carry + button advances two hours.
    if (hr_pulse_q) begin
      hr_d = hr_inc(hr_d);
    end
    if (!state_legal) begin
      sec_d      = ZERO2;
      min_d      = ZERO2;
      hr_d       = HR_RST;
      sec_tick_d = 1'b0;
    end
  end

  always_ff @(posedge ADC_CLK_10) begin
    if (reset) begin
      sec_q      <= ZERO2;
      min_q      <= ZERO2;
      hr_q       <= HR_RST;
      sec_tick_q <= 1'b0;
    end else begin
      sec_q      <= sec_d;
      min_q      <= min_d;
      hr_q       <= hr_d;
      sec_tick_q <= sec_tick_d;
    end
  end

  assign h10      = hr_q.tens;
  assign h1       = hr_q.ones;
  assign m10      = min_q.tens;
  assign m1       = min_q.ones;
  assign sec_tick = sec_tick_q;
  assign colon    = ~sec_q.ones[0];

endmodule

// File: tb/tb_bcd_time_counter.sv
// Directed self-checking bench for bcd_time_counter in 24-hour mode with DIV=4.
module tb_bcd_time_counter;

  localparam int unsigned DIV   = 4;
  localparam int unsigned DIV_W = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic        inc_min_btn = 1'b0;
  logic        inc_hr_btn = 1'b0;
  logic [3:0]  h10, h1, m10, m1;
  logic        sec_tick, colon;
  logic [15:0] digits;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  assign digits = {h10, h1, m10, m1};

  bcd_time_counter #(
    .DIV   (DIV),
    .DIV_W (DIV_W)
  ) dut (
    .ADC_CLK_10  (clk),
    .reset       (reset),
    .run         (run),
    .inc_min_btn (inc_min_btn),
    .inc_hr_btn  (inc_hr_btn),
    .h10         (h10),
    .h1          (h1),
    .m10         (m10),
    .m1          (m1),
    .sec_tick    (sec_tick),
    .colon       (colon)
  );

  // Leaves the bench at the falling edge of cycle 0 (first cycle after the reset edge).
  task automatic do_reset(input logic run_val);
    @(negedge clk);
    reset = 1'b1;
    run = run_val;
    inc_min_btn = 1'b0;
    inc_hr_btn = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic press_min(input int n);
    for (int i = 0; i < n; i++) begin
      inc_min_btn = 1'b1;
      repeat (4) @(negedge clk);
      inc_min_btn = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic press_hr(input int n);
    for (int i = 0; i < n; i++) begin
      inc_hr_btn = 1'b1;
      repeat (4) @(negedge clk);
      inc_hr_btn = 1'b0;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    do_reset(1'b0);
    @(negedge clk);
    total++;
    if (digits !== 16'h0000) begin
      bad++;
      $display("FAIL reset_digits: got %h want 0000", digits);
    end
    total++;
    if (sec_tick !== 1'b0) begin
      bad++;
      $display("FAIL reset_sec_tick: got %b want 0", sec_tick);
    end
    total++;
    if (colon !== 1'b1) begin
      bad++;
      $display("FAIL reset_colon: got %b want 1", colon);
    end
  endtask

  task automatic test_count();
    logic exp_tick, exp_colon;
    do_reset(1'b1);
    for (int k = 1; k <= 240; k++) begin
      @(negedge clk);
      exp_tick = (k % 4) == 0;
      exp_colon = ((k / 4) % 2) == 0;
      total++;
      if (sec_tick !== exp_tick) begin
        bad++;
        $display("FAIL count_sec_tick cycle %0d: got %b want %b", k, sec_tick, exp_tick);
      end
      total++;
      if (colon !== exp_colon) begin
        bad++;
        $display("FAIL count_colon cycle %0d: got %b want %b", k, colon, exp_colon);
      end
      if (k == 236) begin
        total++;
        if (digits !== 16'h0000) begin
          bad++;
          $display("FAIL count_at_59s: got %h want 0000", digits);
        end
      end
    end
    total++;
    if (digits !== 16'h0001) begin
      bad++;
      $display("FAIL count_60_ticks: got %h want 0001", digits);
    end
    run = 1'b0;
  endtask

  task automatic test_rollover();
    do_reset(1'b0);
    press_hr(23);
    press_min(59);
    total++;
    if (digits !== 16'h2359) begin
      bad++;
      $display("FAIL rollover_preset: got %h want 2359", digits);
    end
    run = 1'b1;
    repeat (239) @(negedge clk);
    total++;
    if (digits !== 16'h2359 || sec_tick !== 1'b0) begin
      bad++;
      $display("FAIL rollover_before: got %h/%b want 2359/0", digits, sec_tick);
    end
    @(negedge clk);
    total++;
    if (digits !== 16'h0000 || sec_tick !== 1'b1 || colon !== 1'b1) begin
      bad++;
      $display("FAIL rollover_after: got %h/%b/%b want 0000/1/1", digits, sec_tick, colon);
    end
    run = 1'b0;
  endtask

  task automatic test_inc_min();
    do_reset(1'b0);
    press_hr(10);
    press_min(59);
    run = 1'b1;
    repeat (6) @(negedge clk);
    run = 1'b0;
    total++;
    if (colon !== 1'b0) begin
      bad++;
      $display("FAIL inc_min_odd_second: got colon %b want 0", colon);
    end
    inc_min_btn = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (digits !== 16'h1059) begin
      bad++;
      $display("FAIL inc_min_latency: got %h want 1059", digits);
    end
    @(negedge clk);
    total++;
    if (digits !== 16'h1000 || colon !== 1'b1) begin
      bad++;
      $display("FAIL inc_min_wrap: got %h/%b want 1000/1", digits, colon);
    end
    inc_min_btn = 1'b0;
    repeat (4) @(negedge clk);
    run = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (sec_tick !== 1'b0) begin
      bad++;
      $display("FAIL inc_min_presc_early: got sec_tick %b want 0", sec_tick);
    end
    @(negedge clk);
    total++;
    if (sec_tick !== 1'b1 || digits !== 16'h1000) begin
      bad++;
      $display("FAIL inc_min_presc_cleared: got %b/%h want 1/1000", sec_tick, digits);
    end
    run = 1'b0;
  endtask

  task automatic test_inc_hr();
    do_reset(1'b0);
    press_hr(23);
    press_min(5);
    total++;
    if (digits !== 16'h2305) begin
      bad++;
      $display("FAIL inc_hr_preset: got %h want 2305", digits);
    end
    press_hr(1);
    total++;
    if (digits !== 16'h0005) begin
      bad++;
      $display("FAIL inc_hr_wrap: got %h want 0005", digits);
    end
    press_min(54);
    inc_min_btn = 1'b1;
    inc_hr_btn = 1'b1;
    repeat (4) @(negedge clk);
    inc_min_btn = 1'b0;
    inc_hr_btn = 1'b0;
    repeat (4) @(negedge clk);
    total++;
    if (digits !== 16'h0100) begin
      bad++;
      $display("FAIL inc_both_no_carry: got %h want 0100", digits);
    end
    press_hr(9);
    total++;
    if (digits !== 16'h1000) begin
      bad++;
      $display("FAIL inc_hr_09_to_10: got %h want 1000", digits);
    end
  endtask

  task automatic test_min_with_tick();
    do_reset(1'b1);
    repeat (4) @(negedge clk);
    total++;
    if (sec_tick !== 1'b1) begin
      bad++;
      $display("FAIL coinc_first_tick: got %b want 1", sec_tick);
    end
    inc_min_btn = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (digits !== 16'h0000 || colon !== 1'b0) begin
      bad++;
      $display("FAIL coinc_before: got %h/%b want 0000/0", digits, colon);
    end
    @(negedge clk);
    total++;
    if (digits !== 16'h0001 || sec_tick !== 1'b0 || colon !== 1'b1) begin
      bad++;
      $display("FAIL coinc_min_wins: got %h/%b/%b want 0001/0/1", digits, sec_tick, colon);
    end
    inc_min_btn = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (sec_tick !== 1'b0) begin
      bad++;
      $display("FAIL coinc_restart_early: got %b want 0", sec_tick);
    end
    @(negedge clk);
    total++;
    if (sec_tick !== 1'b1) begin
      bad++;
      $display("FAIL coinc_restart_tick: got %b want 1", sec_tick);
    end
    run = 1'b0;
  endtask

  task automatic test_hr_with_carry();
    do_reset(1'b0);
    press_hr(22);
    press_min(59);
    run = 1'b1;
    repeat (236) @(negedge clk);
    total++;
    if (digits !== 16'h2259) begin
      bad++;
      $display("FAIL hr_carry_preset: got %h want 2259", digits);
    end
    inc_hr_btn = 1'b1;
    repeat (4) @(negedge clk);
    total++;
    if (digits !== 16'h0000 || sec_tick !== 1'b1) begin
      bad++;
      $display("FAIL hr_carry_double: got %h/%b want 0000/1", digits, sec_tick);
    end
    inc_hr_btn = 1'b0;
    run = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_run_freeze();
    do_reset(1'b1);
    repeat (6) @(negedge clk);
    run = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      total++;
      if (sec_tick !== 1'b0 || digits !== 16'h0000 || colon !== 1'b0) begin
        bad++;
        $display("FAIL freeze cycle %0d: got %b/%h/%b want 0/0000/0", i, sec_tick, digits, colon);
      end
    end
    press_hr(1);
    total++;
    if (digits !== 16'h0100) begin
      bad++;
      $display("FAIL freeze_button: got %h want 0100", digits);
    end
    run = 1'b1;
    @(negedge clk);
    total++;
    if (sec_tick !== 1'b0) begin
      bad++;
      $display("FAIL freeze_resume_early: got %b want 0", sec_tick);
    end
    @(negedge clk);
    total++;
    if (sec_tick !== 1'b1 || colon !== 1'b1 || digits !== 16'h0100) begin
      bad++;
      $display("FAIL freeze_resume: got %b/%b/%h want 1/1/0100", sec_tick, colon, digits);
    end
    run = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset(1'b1);
    press_hr(3);
    total++;
    if (digits[15:8] !== 8'h03) begin
      bad++;
      $display("FAIL mid_preset_hours: got %h want 03", digits[15:8]);
    end
    do_reset(1'b1);
    @(negedge clk);
    total++;
    if (digits !== 16'h0000 || colon !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_digits: got %h/%b want 0000/1", digits, colon);
    end
    repeat (2) @(negedge clk);
    total++;
    if (sec_tick !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset_early: got %b want 0", sec_tick);
    end
    @(negedge clk);
    total++;
    if (sec_tick !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_first_tick: got %b want 1", sec_tick);
    end
    run = 1'b0;
  endtask

  initial begin
    test_reset();
    test_count();
    test_rollover();
    test_inc_min();
    test_inc_hr();
    test_min_with_tick();
    test_hr_with_carry();
    test_run_freeze();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
